ad7606_sample_drv: RTL

Downstream consumer of the ADC control-register stage. Takes capture settings (channel count, enable, sample period, trigger mode, status query) and drives the AD7606 parallel interface: hardware reset, CONVST, BUSY wait, and CS_n/RD_n read of N channels. Emits one 16-bit sample per channel as a valid/last stream toward the upload path. Also answers status queries with a conversion count.

---
 rtl/ad7606_pkg.sv | 43 ++++
 rtl/ad7606_sync_edge.sv | 26 ++
 rtl/ad7606_sample_drv.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 sample driver.
package ad7606_pkg;

  typedef enum logic [3:0] {
    ST_ADRST   = 4'd0,
    ST_IDLE    = 4'd1,
    ST_ARM     = 4'd2,
    ST_CONVST  = 4'd3,
    ST_BUSY_H  = 4'd4,
    ST_BUSY_L  = 4'd5,
    ST_RD_LOW  = 4'd6,
    ST_RD_HIGH = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam int MAX_CHN = 8;

  localparam int DEF_RST_CYC        = 50;
  localparam int DEF_CONVST_LOW_CYC = 5;
  localparam int DEF_RD_LOW_CYC     = 4;
  localparam int DEF_RD_HIGH_CYC    = 3;
  localparam int DEF_BUSY_TO_CYC    = 5000;
  localparam int DEF_MIN_PERIOD     = 200;

  localparam logic TRIG_FREE = 1'b0;
  localparam logic TRIG_EXT  = 1'b1;

  // 0 and anything above MAX_CHN select the full channel set
  function automatic logic [3:0] chn_count(input logic [7:0] num);
    if (num == 8'd0 || num > 8'(MAX_CHN)) begin
      return 4'(MAX_CHN);
    end else begin
      return num[3:0];
    end
  endfunction

  // Counter reload so that frame starts land exactly one period apart
  function automatic logic [23:0] period_reload(input logic [23:0] speed,
                                                input logic [23:0] min_period);
    return ((speed > min_period) ? speed : min_period) - 24'd1;
  endfunction

endpackage

// File: rtl/ad7606_sync_edge.sv
// Two-flop synchronizer with a rising-edge strobe on the synchronized level.
module ad7606_sync_edge
  import ad7606_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [2:0] sync;

  // Shift register: two metastability stages plus one history stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], din};
    end
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~sync[2];

endmodule

// File: rtl/ad7606_sample_drv.sv
// AD7606 parallel-interface driver: reset, CONVST, BUSY wait, N-channel read.
// Optional AD7606_TEST_PATTERN_EN replaces bus data with {frame_cnt, chn}.
module ad7606_sample_drv
  import ad7606_pkg::*;
#(
  parameter int RST_CYC        = DEF_RST_CYC,
  parameter int CONVST_LOW_CYC = DEF_CONVST_LOW_CYC,
  parameter int RD_LOW_CYC     = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC    = DEF_RD_HIGH_CYC,
  parameter int BUSY_TO_CYC    = DEF_BUSY_TO_CYC,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_cap_chnnel_num,
  input  logic        i_cap_enable,
  input  logic [23:0] i_cap_speed,
  input  logic        i_cap_trigger,
  input  logic        i_cap_seek,
  input  logic        i_ext_trig,
  input  logic        i_ad_busy,
  input  logic [15:0] i_ad_db,
  output logic        o_ad_reset,
  output logic        o_ad_convst,
  output logic        o_ad_cs_n,
  output logic        o_ad_rd_n,
  output logic [15:0] o_adc_data,
  output logic [2:0]  o_adc_chn,
  output logic        o_adc_valid,
  output logic        o_adc_last,
  output logic [31:0] o_seek_cnt,
  output logic        o_seek_valid,
  output logic        o_err_timeout,
  output logic        o_overrun
);

  localparam logic [15:0] RST_LAST     = 16'(RST_CYC - 1);
  localparam logic [15:0] CONVST_LAST  = 16'(CONVST_LOW_CYC - 1);
  localparam logic [15:0] RD_LOW_LAST  = 16'(RD_LOW_CYC - 1);
  localparam logic [15:0] RD_HIGH_LAST = 16'(RD_HIGH_CYC - 1);
  localparam logic [15:0] BUSY_TO_LAST = 16'(BUSY_TO_CYC - 1);

  state_t      state;
  logic [15:0] tmr;
  logic [23:0] period_cnt;
  logic [3:0]  n_lat;
  logic [2:0]  chn_idx;
  logic        en_d;
  logic        en_rise;
  logic        in_frame;
  logic        last_chn;
  logic        busy_s;
  logic        busy_rise;
  logic        trig_lvl;
  logic        trig_rise;
  logic [15:0] sample;
  logic        unused;

  ad7606_sync_edge u_busy_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .din   (i_ad_busy),
    .level (busy_s),
    .rise  (busy_rise)
  );

  ad7606_sync_edge u_trig_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .din   (i_ext_trig),
    .level (trig_lvl),
    .rise  (trig_rise)
  );

`ifdef AD7606_TEST_PATTERN_EN
  assign sample = {o_seek_cnt[12:0], chn_idx};
  assign unused = ^{trig_lvl, busy_rise, i_ad_db};
`else
  assign sample = i_ad_db;
  assign unused = ^{trig_lvl, busy_rise};
`endif

  assign en_rise  = i_cap_enable & ~en_d;
  assign in_frame = (state inside {ST_CONVST, ST_BUSY_H, ST_BUSY_L,
                                   ST_RD_LOW, ST_RD_HIGH, ST_DONE});
  assign last_chn = ({1'b0, chn_idx} == (n_lat - 4'd1));

  // Sequencer: chip reset, conversion, BUSY handshake, channel reads, status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_ADRST;
      tmr           <= 16'd0;
      period_cnt    <= 24'd0;
      n_lat         <= 4'(MAX_CHN);
      chn_idx       <= 3'd0;
      en_d          <= 1'b0;
      o_ad_reset    <= 1'b1;
      o_ad_convst   <= 1'b1;
      o_ad_cs_n     <= 1'b1;
      o_ad_rd_n     <= 1'b1;
      o_adc_data    <= 16'd0;
      o_adc_chn     <= 3'd0;
      o_adc_valid   <= 1'b0;
      o_adc_last    <= 1'b0;
      o_seek_cnt    <= 32'd0;
      o_seek_valid  <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      en_d         <= i_cap_enable;
      o_adc_valid  <= 1'b0;
      o_adc_last   <= 1'b0;
      o_seek_valid <= i_cap_seek;
      if (period_cnt != 24'd0) begin
        period_cnt <= period_cnt - 24'd1;
      end
      if (in_frame && period_cnt == 24'd0) begin
        o_overrun <= 1'b1;
      end

      case (state)
        ST_ADRST: begin
          if (tmr == RST_LAST) begin
            o_ad_reset <= 1'b0;
            tmr        <= 16'd0;
            state      <= ST_IDLE;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_IDLE: begin
          period_cnt <= 24'd0;
          if (i_cap_enable) begin
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (!i_cap_enable) begin
            state <= ST_IDLE;
          end else if ((i_cap_trigger == TRIG_FREE && period_cnt == 24'd0) ||
                       (i_cap_trigger == TRIG_EXT && trig_rise)) begin
            n_lat       <= chn_count(i_cap_chnnel_num);
            period_cnt  <= period_reload(i_cap_speed, 24'(MIN_PERIOD));
            chn_idx     <= 3'd0;
            tmr         <= 16'd0;
            o_ad_convst <= 1'b0;
            state       <= ST_CONVST;
          end
        end
        ST_CONVST: begin
          if (tmr == CONVST_LAST) begin
            o_ad_convst <= 1'b1;
            tmr         <= 16'd0;
            state       <= ST_BUSY_H;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_BUSY_H: begin
          if (busy_s) begin
            tmr   <= 16'd0;
            state <= ST_BUSY_L;
          end else if (tmr == BUSY_TO_LAST) begin
            o_err_timeout <= 1'b1;
            o_ad_reset    <= 1'b1;
            tmr           <= 16'd0;
            state         <= ST_ADRST;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_BUSY_L: begin
          if (!busy_s) begin
            o_ad_cs_n <= 1'b0;
            o_ad_rd_n <= 1'b0;
            tmr       <= 16'd0;
            state     <= ST_RD_LOW;
          end else if (tmr == BUSY_TO_LAST) begin
            o_err_timeout <= 1'b1;
            o_ad_reset    <= 1'b1;
            tmr           <= 16'd0;
            state         <= ST_ADRST;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_RD_LOW: begin
          if (tmr == RD_LOW_LAST) begin
            o_adc_data  <= sample;
            o_adc_chn   <= chn_idx;
            o_adc_valid <= 1'b1;
            o_adc_last  <= last_chn;
            o_ad_rd_n   <= 1'b1;
            tmr         <= 16'd0;
            state       <= ST_RD_HIGH;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_RD_HIGH: begin
          if (tmr == RD_HIGH_LAST) begin
            tmr <= 16'd0;
            if (last_chn) begin
              o_ad_cs_n <= 1'b1;
              state     <= ST_DONE;
            end else begin
              chn_idx   <= chn_idx + 3'd1;
              o_ad_rd_n <= 1'b0;
              state     <= ST_RD_LOW;
            end
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_DONE: begin
          o_seek_cnt <= o_seek_cnt + 32'd1;
          state      <= i_cap_enable ? ST_ARM : ST_IDLE;
        end
        default: begin
          o_ad_reset  <= 1'b1;
          o_ad_convst <= 1'b1;
          o_ad_cs_n   <= 1'b1;
          o_ad_rd_n   <= 1'b1;
          tmr         <= 16'd0;
          state       <= ST_ADRST;
        end
      endcase

      // A fresh capture session starts its statistics from zero
      if (en_rise) begin
        o_seek_cnt    <= 32'd0;
        o_overrun     <= 1'b0;
        o_err_timeout <= 1'b0;
      end
    end
  end

endmodule
